// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        DATA_PRI  = 1'b0,
        FETCH_PRI = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic valid;
        logic is_fetch;
    } tag_t;

    localparam int MAX_MEM_LAT = 4;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two pipeline requesters, the arbiter and the memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import mem_arb_pkg::*;

    localparam int STRB_W = strb_w(DATA_W);

    logic              flush;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/mem_port_arbiter_resp_tag_pipe.sv
// Read-response owner tracking: a MEM_LAT-deep tag shift register whose head
// says which stage (if any) the current mem_rdata belongs to.
module resp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  tag_t issue,
    output logic if_rvalid,
    output logic d_rvalid
);

    tag_t tag_r [MEM_LAT];
    tag_t head_s;

    // Shift tags toward the head; fetch tags passing through a flush cycle are killed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0].valid    <= issue.valid & ~(flush & issue.is_fetch);
            tag_r[0].is_fetch <= issue.is_fetch;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_r[i].valid    <= tag_r[i-1].valid & ~(flush & tag_r[i-1].is_fetch);
                tag_r[i].is_fetch <= tag_r[i-1].is_fetch;
            end
        end
    end

    // Owner decode; a fetch response arriving during flush is dropped as stale.
    always_comb begin
        head_s    = tag_r[MEM_LAT-1];
        if_rvalid = head_s.valid & head_s.is_fetch & ~flush;
        d_rvalid  = head_s.valid & ~head_s.is_fetch;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data-first priority with a fetch anti-starvation
// cap, one grant per cycle, owner-routed read responses and flush kill.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LAT     = 1,
    parameter int MAX_D_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int STRB_W = strb_w(DATA_W);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [3:0]        streak_r;
    logic [3:0]        streak_nxt_s;
    logic [3:0]        streak_inc_s;
    logic              fetch_ok_s;
    logic              if_gnt_s;
    logic              d_gnt_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [STRB_W-1:0] mem_wstrb_s;
    tag_t              issue_s;
    logic              if_rvalid_s;
    logic              d_rvalid_s;

    // Grant selection; flush blocks fetch and reset blocks everything.
    always_comb begin
        if_gnt_s   = 1'b0;
        d_gnt_s    = 1'b0;
        fetch_ok_s = bus.if_req & ~bus.flush;
        case (state_r)
            DATA_PRI: begin
                d_gnt_s  = bus.d_req;
                if_gnt_s = fetch_ok_s & ~bus.d_req;
            end
            FETCH_PRI: begin
                if_gnt_s = fetch_ok_s;
                d_gnt_s  = bus.d_req & ~fetch_ok_s;
            end
            default: begin
                d_gnt_s  = bus.d_req;
                if_gnt_s = fetch_ok_s & ~bus.d_req;
            end
        endcase
        if_gnt_s = if_gnt_s & rst;
        d_gnt_s  = d_gnt_s & rst;
    end

    // Priority FSM and streak of data grants taken while fetch was waiting.
    always_comb begin
        state_nxt_s  = state_r;
        streak_nxt_s = streak_r;
        streak_inc_s = streak_r + 4'd1;
        case (state_r)
            DATA_PRI: begin
                if (!bus.if_req || if_gnt_s) begin
                    streak_nxt_s = 4'd0;
                end else if (d_gnt_s) begin
                    streak_nxt_s = streak_inc_s;
                    if (streak_inc_s == 4'(MAX_D_BURST)) begin
                        state_nxt_s = FETCH_PRI;
                    end else begin
                        state_nxt_s = DATA_PRI;
                    end
                end else begin
                    streak_nxt_s = streak_r;
                end
            end
            FETCH_PRI: begin
                if (!bus.if_req || if_gnt_s) begin
                    state_nxt_s  = DATA_PRI;
                    streak_nxt_s = 4'd0;
                end else begin
                    state_nxt_s  = FETCH_PRI;
                end
            end
            default: begin
                state_nxt_s  = DATA_PRI;
                streak_nxt_s = 4'd0;
            end
        endcase
    end

    // Priority state and streak registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= DATA_PRI;
            streak_r <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            streak_r <= streak_nxt_s;
        end
    end

    // Memory request mux; fetches never write.
    always_comb begin
        if (d_gnt_s) begin
            mem_addr_s  = bus.d_addr;
            mem_wdata_s = bus.d_wdata;
            mem_wstrb_s = bus.d_wstrb;
        end else begin
            mem_addr_s  = bus.if_addr;
            mem_wdata_s = '0;
            mem_wstrb_s = '0;
        end
        issue_s.valid    = if_gnt_s | (d_gnt_s & ~bus.d_we);
        issue_s.is_fetch = if_gnt_s;
    end

    resp_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tags (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .issue     (issue_s),
        .if_rvalid (if_rvalid_s),
        .d_rvalid  (d_rvalid_s)
    );

    assign bus.if_gnt    = if_gnt_s;
    assign bus.d_gnt     = d_gnt_s;
    assign bus.mem_en    = if_gnt_s | d_gnt_s;
    assign bus.mem_we    = d_gnt_s & bus.d_we;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.mem_wstrb = mem_wstrb_s;
    assign bus.if_rvalid = if_rvalid_s & rst;
    assign bus.d_rvalid  = d_rvalid_s & rst;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_D_BURST(4)) dut (
        .clk (clk), .rst (rst), .bus (b1)
    );
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_D_BURST(4)) dut3 (
        .clk (clk), .rst (rst), .bus (b3)
    );

    // {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we}
    logic [5:0] st1;
    logic [5:0] st3;
    assign st1 = {b1.if_gnt, b1.d_gnt, b1.if_rvalid, b1.d_rvalid, b1.mem_en, b1.mem_we};
    assign st3 = {b3.if_gnt, b3.d_gnt, b3.if_rvalid, b3.d_rvalid, b3.mem_en, b3.mem_we};

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_all();
        b1.flush = 1'b0; b1.if_req = 1'b0; b1.if_addr = 32'h0; b1.d_req = 1'b0;
        b1.d_we = 1'b0; b1.d_addr = 32'h0; b1.d_wdata = 32'h0; b1.d_wstrb = 4'h0;
        b3.flush = 1'b0; b3.if_req = 1'b0; b3.if_addr = 32'h0; b3.d_req = 1'b0;
        b3.d_we = 1'b0; b3.d_addr = 32'h0; b3.d_wdata = 32'h0; b3.d_wstrb = 4'h0;
        b1.mem_rdata = 32'h0; b3.mem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b0;
        b1.if_req = 1'b1; b1.d_req = 1'b1; b1.d_we = 1'b1;
        b3.if_req = 1'b1; b3.d_req = 1'b1;
        mid();
        checks++; if (st1 !== 6'b000000) begin errors++; $display("FAIL reset_outputs got %b exp 000000", st1); end
        checks++; if (st3 !== 6'b000000) begin errors++; $display("FAIL reset_outputs3 got %b exp 000000", st3); end
        next_cycle(); mid();
        checks++; if (st1 !== 6'b000000) begin errors++; $display("FAIL reset_held got %b exp 000000", st1); end
        next_cycle();
        rst = 1'b1;
        idle_all();
        mid();
        checks++; if (st1 !== 6'b000000) begin errors++; $display("FAIL post_reset_idle got %b exp 000000", st1); end
    endtask

    task automatic test_fetch_only();
        next_cycle();
        b1.if_req = 1'b1; b1.if_addr = 32'h100;
        mid();
        checks++; if (st1 !== 6'b100010) begin errors++; $display("FAIL fetch_grant got %b exp 100010", st1); end
        checks++; if (b1.mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_addr got %h exp 00000100", b1.mem_addr); end
        checks++; if (b1.mem_wstrb !== 4'h0) begin errors++; $display("FAIL fetch_wstrb got %h exp 0", b1.mem_wstrb); end
        next_cycle();
        b1.if_req = 1'b0; b1.mem_rdata = 32'h00500093;
        mid();
        checks++; if (st1 !== 6'b001000) begin errors++; $display("FAIL fetch_rvalid got %b exp 001000", st1); end
        checks++; if (b1.if_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_rdata got %h exp 00500093", b1.if_rdata); end
        next_cycle(); mid();
        checks++; if (st1 !== 6'b000000) begin errors++; $display("FAIL fetch_after got %b exp 000000", st1); end
    endtask

    task automatic test_priority();
        next_cycle();
        b1.if_req = 1'b1; b1.if_addr = 32'h104;
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h2000;
        mid();
        checks++; if (st1 !== 6'b010010) begin errors++; $display("FAIL prio_data_first got %b exp 010010", st1); end
        checks++; if (b1.mem_addr !== 32'h2000) begin errors++; $display("FAIL prio_data_addr got %h exp 00002000", b1.mem_addr); end
        next_cycle();
        b1.d_req = 1'b0; b1.mem_rdata = 32'h11112222;
        mid();
        checks++; if (st1 !== 6'b100110) begin errors++; $display("FAIL prio_fetch_next got %b exp 100110", st1); end
        checks++; if (b1.d_rdata !== 32'h11112222) begin errors++; $display("FAIL prio_d_rdata got %h exp 11112222", b1.d_rdata); end
        checks++; if (b1.mem_addr !== 32'h104) begin errors++; $display("FAIL prio_fetch_addr got %h exp 00000104", b1.mem_addr); end
        next_cycle();
        b1.if_req = 1'b0; b1.mem_rdata = 32'h33334444;
        mid();
        checks++; if (st1 !== 6'b001000) begin errors++; $display("FAIL prio_if_rvalid got %b exp 001000", st1); end
        checks++; if (b1.if_rdata !== 32'h33334444) begin errors++; $display("FAIL prio_if_rdata got %h exp 33334444", b1.if_rdata); end
        next_cycle();
    endtask

    task automatic test_starvation();
        logic [1:0] exp_g;
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h2010;
        b1.if_req = 1'b1; b1.if_addr = 32'h108;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) next_cycle();
            mid();
            exp_g = (k == 4) ? 2'b10 : 2'b01;
            checks++;
            if ({b1.if_gnt, b1.d_gnt} !== exp_g) begin
                errors++; $display("FAIL starve_cycle%0d got %b exp %b", k, {b1.if_gnt, b1.d_gnt}, exp_g);
            end
        end
        next_cycle();
        b1.if_req = 1'b0; b1.d_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_store();
        b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h2004;
        b1.d_wdata = 32'hDEADBEEF; b1.d_wstrb = 4'hF;
        mid();
        checks++; if (st1 !== 6'b010011) begin errors++; $display("FAIL store_grant got %b exp 010011", st1); end
        checks++; if (b1.mem_addr !== 32'h2004) begin errors++; $display("FAIL store_addr got %h exp 00002004", b1.mem_addr); end
        checks++; if (b1.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata got %h exp deadbeef", b1.mem_wdata); end
        checks++; if (b1.mem_wstrb !== 4'hF) begin errors++; $display("FAIL store_wstrb got %h exp f", b1.mem_wstrb); end
        next_cycle();
        b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_wstrb = 4'h0;
        for (int k = 1; k <= 4; k++) begin
            mid();
            checks++; if (st1 !== 6'b000000) begin errors++; $display("FAIL store_no_rvalid_t%0d got %b exp 000000", k, st1); end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        // MEM_LAT=1: fetch response landing in the flush cycle is dropped
        b1.if_req = 1'b1; b1.if_addr = 32'h10C;
        mid();
        checks++; if (st1 !== 6'b100010) begin errors++; $display("FAIL flush1_grant got %b exp 100010", st1); end
        next_cycle();
        b1.if_req = 1'b0; b1.flush = 1'b1;
        mid();
        checks++; if (st1 !== 6'b000000) begin errors++; $display("FAIL flush1_suppress got %b exp 000000", st1); end
        next_cycle();
        b1.flush = 1'b0;
        // MEM_LAT=3: two fetches in flight, flush, then a load
        b3.if_req = 1'b1; b3.if_addr = 32'h200;
        mid();
        checks++; if (st3 !== 6'b100010) begin errors++; $display("FAIL flush3_fetch_t0 got %b exp 100010", st3); end
        next_cycle();
        b3.if_addr = 32'h204;
        mid();
        checks++; if (st3 !== 6'b100010) begin errors++; $display("FAIL flush3_fetch_t1 got %b exp 100010", st3); end
        next_cycle();
        b3.flush = 1'b1; b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h3000;
        mid();
        checks++; if (st3 !== 6'b010010) begin errors++; $display("FAIL flush3_t2 got %b exp 010010", st3); end
        next_cycle();
        b3.flush = 1'b0; b3.if_req = 1'b0; b3.d_req = 1'b0;
        mid();
        checks++; if (st3 !== 6'b000000) begin errors++; $display("FAIL flush3_t3 got %b exp 000000", st3); end
        next_cycle(); mid();
        checks++; if (st3 !== 6'b000000) begin errors++; $display("FAIL flush3_t4 got %b exp 000000", st3); end
        next_cycle();
        b3.mem_rdata = 32'hCAFEF00D;
        mid();
        checks++; if (st3 !== 6'b000100) begin errors++; $display("FAIL flush3_load_t5 got %b exp 000100", st3); end
        checks++; if (b3.d_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL flush3_d_rdata got %h exp cafef00d", b3.d_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        logic [1:0] exp_g;
        b1.if_req = 1'b1; b1.if_addr = 32'h110;
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h2008;
        mid();
        checks++; if ({b1.if_gnt, b1.d_gnt} !== 2'b01) begin errors++; $display("FAIL rstmid_pre got %b exp 01", {b1.if_gnt, b1.d_gnt}); end
        next_cycle(); mid();
        checks++; if ({b1.if_gnt, b1.d_gnt} !== 2'b01) begin errors++; $display("FAIL rstmid_load got %b exp 01", {b1.if_gnt, b1.d_gnt}); end
        rst = 1'b0;
        #1;
        checks++; if (st1 !== 6'b000000) begin errors++; $display("FAIL rstmid_async got %b exp 000000", st1); end
        for (int k = 0; k < 2; k++) begin
            next_cycle(); mid();
            checks++; if (st1 !== 6'b000000) begin errors++; $display("FAIL rstmid_held%0d got %b exp 000000", k, st1); end
        end
        next_cycle();
        rst = 1'b1;
        b1.if_req = 1'b0; b1.d_req = 1'b0;
        mid();
        checks++; if (st1 !== 6'b000000) begin errors++; $display("FAIL rstmid_no_stale got %b exp 000000", st1); end
        next_cycle();
        b1.if_req = 1'b1; b1.d_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            mid();
            exp_g = (k == 4) ? 2'b10 : 2'b01;
            checks++;
            if ({b1.if_gnt, b1.d_gnt} !== exp_g) begin
                errors++; $display("FAIL rstmid_streak%0d got %b exp %b", k, {b1.if_gnt, b1.d_gnt}, exp_g);
            end
        end
        next_cycle();
        idle_all();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_priority();
        test_starvation();
        test_store();
        test_flush();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
